// File: rtl/uart_tx_frame_arbiter.sv
// Round-robin arbiter that lets NREQ frame sources (1..3 bytes each) share one uart_byte_tx.
// Optional WAIT-state abort on a missing Tx_Done edge: define UART_TX_TIMEOUT_EN.
module uart_tx_frame_arbiter #(
  parameter int NREQ           = 4,
  parameter int IDW            = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*24-1:0] req_data,
  input  logic [NREQ*2-1:0] req_len,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err,
  output logic              busy,
  output logic [IDW-1:0]    grant_id,
  output logic [7:0]        tx_data_byte,
  output logic              tx_send_en,
  input  logic              tx_done,
  output logic [4:0]        fsm_state
);

  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    LOAD = 5'b00010,
    SEND = 5'b00100,
    WAIT = 5'b01000,
    FIN  = 5'b10000
  } state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] last_ptr;
  logic [IDW-1:0] sel_idx;
  logic           sel_found;
  int unsigned    cand;
  logic [23:0]    shift_reg;
  logic [1:0]     rem;
  logic           tx_done_d;
  logic           tx_edge;
  logic           timeout;
  logic [23:0]    grant_data;
  logic [1:0]     grant_len;

  assign tx_edge    = tx_done & ~tx_done_d;
  assign busy       = (state != IDLE);
  assign fsm_state  = state;
  assign grant_data = req_data[24*grant_id +: 24];
  assign grant_len  = req_len[2*grant_id +: 2];

  // First pending requester strictly after the last grant, wrapping at NREQ-1.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    cand      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_ptr) + k) % NREQ;
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDW-1:0];
      end
    end
  end

`ifdef UART_TX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n || state == SEND)
      wait_cnt <= '0;
    else if (state == WAIT && wait_cnt != CW'(TIMEOUT_CYCLES))
      wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout = (state == WAIT) && !tx_edge && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    done       = '0;
    err        = '0;
    tx_send_en = 1'b0;
    case (state)
      IDLE: if (sel_found) state_nxt = LOAD;
      LOAD: state_nxt = (grant_len == 2'd0) ? FIN : SEND;
      SEND: begin
        tx_send_en = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (timeout) begin
          err[grant_id] = 1'b1;
          state_nxt     = IDLE;
        end else if (tx_edge) begin
          state_nxt = (rem == 2'd1) ? FIN : SEND;
        end
      end
      FIN: begin
        done[grant_id] = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // tx_data_byte is loaded on the way into SEND so it is already valid while send_en is high.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      last_ptr     <= IDW'(NREQ - 1);
      grant_id     <= '0;
      shift_reg    <= '0;
      rem          <= '0;
      tx_data_byte <= '0;
      tx_done_d    <= 1'b0;
    end else begin
      state     <= state_nxt;
      tx_done_d <= tx_done;
      case (state)
        IDLE: if (sel_found) grant_id <= sel_idx;
        LOAD: begin
          shift_reg <= grant_data;
          rem       <= grant_len;
          if (grant_len != 2'd0) tx_data_byte <= grant_data[23:16];
        end
        WAIT: begin
          if (timeout) begin
            last_ptr <= grant_id;
            rem      <= '0;
          end else if (tx_edge) begin
            rem       <= rem - 2'd1;
            shift_reg <= shift_reg << 8;
            if (rem != 2'd1) tx_data_byte <= shift_reg[15:8];
          end
        end
        FIN: last_ptr <= grant_id;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// Randomized bench for uart_tx_frame_arbiter: a queue-free round-robin model predicts grants and byte streams.
// Define UART_TX_TIMEOUT_EN to include the abort scenario.
module tb_uart_tx_frame_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*24-1:0] req_data;
  logic [NREQ*2-1:0] req_len;
  logic [NREQ-1:0]   done;
  logic [NREQ-1:0]   err;
  logic              busy;
  logic [IDW-1:0]    grant_id;
  logic [7:0]        tx_data_byte;
  logic              tx_send_en;
  logic              tx_done;
  logic [4:0]        fsm_state;

  int n_checks = 0;
  int n_errors = 0;
  int send_cnt = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int m_last;
  logic [31:0] grants_q[$];

  uart_tx_frame_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data), .req_len(req_len),
    .done(done), .err(err), .busy(busy), .grant_id(grant_id), .tx_data_byte(tx_data_byte),
    .tx_send_en(tx_send_en), .tx_done(tx_done), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_send_en) send_cnt++;
    if (|done) done_cnt++;
    if (|err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int next_grant(input logic [NREQ-1:0] m, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (m[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
    tx_done = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_last  = NREQ - 1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_send", 32'(tx_send_en), 0);
    check("rst_byte", 32'(tx_data_byte), 0);
    check("rst_grant", 32'(grant_id), 0);
  endtask

  task automatic wait_send(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tx_send_en) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("send_wait", 0, 1);
  endtask

  task automatic wait_done(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (|done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("done_wait", 0, 1);
  endtask

  task automatic pulse_tx_done();
    repeat ($urandom_range(1, 6)) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  // driver: hold mask, serve nframes frames, drop req on the last done pulse
  task automatic run_frames(input logic [NREQ-1:0] mask, input int nframes);
    int g, len, s0;
    logic [23:0] fd;
    logic ok;
    req = mask;
    for (int f = 0; f < nframes; f++) begin
      g   = next_grant(mask, m_last);
      len = int'(req_len[2*g +: 2]);
      fd  = req_data[24*g +: 24];
      s0  = send_cnt;
      for (int b = 0; b < len; b++) begin
        wait_send(ok);
        check("grant", 32'(grant_id), 32'(g));
        if (b == 0) grants_q.push_back(32'(grant_id));
        check("byte", 32'(tx_data_byte), 32'(fd[23-8*b -: 8]));
        pulse_tx_done();
      end
      wait_done(ok);
      check("done", 32'(done), 32'(1 << g));
      check("nbytes", 32'(send_cnt - s0), 32'(len));
      m_last = g;
      if (f == nframes - 1) req = '0;
    end
  endtask

  task automatic randomize_frames();
    for (int i = 0; i < NREQ; i++) begin
      req_data[24*i +: 24] = 24'($urandom);
      req_len[2*i +: 2]    = 2'($urandom_range(1, 3));
    end
  endtask

  initial begin
    int s0, d0, cyc;
    logic ok;
    logic [31:0] rr_exp[6];
    req_data = '0;
    req_len  = '0;
    do_reset();

    // single 3-byte frame
    req_data[23:0] = 24'h414243;
    req_len[1:0]   = 2'd3;
    run_frames(4'b0001, 1);
    @(negedge clk);
    check("single_idle", 32'(busy), 0);

    // round robin with req 1011 held
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_data[24*i +: 24] = {8'(8'h10 + i), 16'h0};
      req_len[2*i +: 2]    = 2'd1;
    end
    grants_q.delete();
    run_frames(4'b1011, 6);
    rr_exp = '{0, 1, 3, 0, 1, 3};
    for (int i = 0; i < 6; i++)
      check("rr_order", (i < grants_q.size()) ? grants_q[i] : 32'hffff_ffff, rr_exp[i]);

    // zero-length frame
    do_reset();
    req_len[5:4] = 2'd0;
    s0  = send_cnt;
    req = 4'b0100;
    cyc = 0;
    while (done == 0 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    req = '0;
    check("len0_done", 32'(done), 32'h4);
    check("len0_lat", 32'(cyc <= 3), 1);
    check("len0_nosend", 32'(send_cnt - s0), 0);

    // stale Tx_Done level
    do_reset();
    req_data[23:0] = 24'h5a6b7c;
    req_len[1:0]   = 2'd1;
    tx_done = 1'b1;
    s0  = send_cnt;
    req = 4'b0001;
    wait_send(ok);
    check("stale_byte", 32'(tx_data_byte), 32'h5a);
    repeat (10) @(negedge clk);
    check("stale_hold_done", 32'(done), 0);
    check("stale_hold_busy", 32'(busy), 1);
    tx_done = 1'b0;
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    wait_done(ok);
    req = '0;
    check("stale_done", 32'(done), 32'h1);
    check("stale_nbytes", 32'(send_cnt - s0), 1);

    // reset in the middle of a 3-byte frame
    do_reset();
    req_data[23:0] = 24'h010203;
    req_len[1:0]   = 2'd3;
    req = 4'b0001;
    wait_send(ok);
    pulse_tx_done();
    wait_send(ok);
    check("mid_byte2", 32'(tx_data_byte), 32'h02);
    d0 = done_cnt;
    do_reset();
    repeat (5) @(negedge clk);
    check("mid_nodone", 32'(done_cnt - d0), 0);
    randomize_frames();
    grants_q.delete();
    run_frames(4'b0011, 1);
    check("mid_restart", (grants_q.size() > 0) ? grants_q[0] : 32'hffff_ffff, 0);

`ifdef UART_TX_TIMEOUT_EN
    // Tx_Done never rises: abort after 50 WAIT cycles, then serve requester 1
    do_reset();
    randomize_frames();
    d0  = done_cnt;
    req = 4'b0011;
    wait_send(ok);
    check("to_grant", 32'(grant_id), 0);
    cyc = 0;
    while (err == 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("to_err", 32'(err), 32'h1);
    check("to_cycles", 32'(cyc), 50);
    check("to_nodone", 32'(done_cnt - d0), 0);
    m_last = 0;
    run_frames(4'b0011, 1);
`endif

    // random masks, lengths, data and Tx_Done delays
    do_reset();
    for (int r = 0; r < 8; r++) begin
      randomize_frames();
      run_frames(4'($urandom_range(1, 15)), $urandom_range(2, 6));
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end

`ifdef UART_TX_TIMEOUT_EN
    check("err_total", 32'(err_cnt), 1);
`else
    check("err_total", 32'(err_cnt), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

endmodule
